// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Holds the FSM state enum, ALU op codes, mux select encodings and opcodes.
// Pure declarations: no latency, no flow control.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_ALU, ST_ALU_WB, ST_MEM_ADR, ST_MEM_RD, ST_MEM_WB,
    ST_MEM_WR, ST_BRANCH, ST_JAL, ST_JALR, ST_LUI, ST_HALT
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_IMM = 2'd3;

  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_OLD_IMM = 2'd1;
  localparam logic [1:0] PC_ALU     = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_OPIMM  = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  // States that hold a memory request open until MemReady_i.
  function automatic logic is_wait_state(state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle: instruction, flags, ready, strobes.
// master = control unit (drives strobes), slave = datapath side.
// Ports: Instr_i/Flags_i/MemReady_i into the unit; all *_o strobes out of it.
interface multicycle_control_unit_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [31:0]           Instr_i;
  logic [2:0]            Flags_i;
  logic                  MemReady_i;
  logic                  MemReq_o;
  logic                  MemWrite_o;
  logic                  AdrSrc_o;
  logic                  IRWrite_o;
  logic                  PCWrite_o;
  logic [1:0]            PCsrc_o;
  logic                  RegWrite_o;
  logic                  ALUsrc_o;
  logic [2:0]            ImmSrc_o;
  logic [ALU_CTRL_W-1:0] ALUctrl_o;
  logic [1:0]            ResultSrc_o;
  logic                  BusErr_o;
  logic                  Illegal_o;

  modport master (
    input  Instr_i, Flags_i, MemReady_i,
    output MemReq_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, PCsrc_o, RegWrite_o,
           ALUsrc_o, ImmSrc_o, ALUctrl_o, ResultSrc_o, BusErr_o, Illegal_o
  );

  modport slave (
    output Instr_i, Flags_i, MemReady_i,
    input  MemReq_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, PCsrc_o, RegWrite_o,
           ALUsrc_o, ImmSrc_o, ALUctrl_o, ResultSrc_o, BusErr_o, Illegal_o
  );
endinterface

// File: rtl/cu_alu_decoder.sv
// ALU operation decode from funct3, funct7[5] and op[5].
// Purely combinational, zero latency; no flow control.
// Ports: funct3_i, funct7_5_i, op5_i in; alu_op_o out.
module cu_alu_decoder
  import cu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       op5_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (funct3_i)
      // funct7 selects SUB only for register-register ops; ADDI ignores it.
      3'd0: alu_op_o = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
      3'd1: alu_op_o = ALU_SLL;
      3'd2: alu_op_o = ALU_SLT;
      3'd3: alu_op_o = ALU_SLTU;
      3'd4: alu_op_o = ALU_XOR;
      // Right shifts use funct7 for both SRL/SRA and SRLI/SRAI.
      3'd5: alu_op_o = funct7_5_i ? ALU_SRA : ALU_SRL;
      3'd6: alu_op_o = ALU_OR;
      default: alu_op_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: Moore FSM driving the shared-memory datapath.
// Latency: outputs decode registered state and Instr_i in the same cycle.
// Backpressure: wait states hold MemReq_o until MemReady_i; TIMEOUT idle cycles halt with BusErr_o.
// Ports: clk_i, rst_i (sync, active-high) and bus (multicycle_control_unit_if.master).
// Option: define MULTICYCLE_CU_TRAP_EN to halt on illegal instructions and raise Illegal_o.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  multicycle_control_unit_if.master   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_q, berr_d;
  logic             illegal;

  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src;
  logic [1:0] pc_src, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl, alu_dec;
  logic       br_ok, taken;

  logic [6:0] op;
  logic [2:0] f3;
  assign op = bus.Instr_i[6:0];
  assign f3 = bus.Instr_i[14:12];

  wire unused_instr = ^{bus.Instr_i[31], bus.Instr_i[29:15], bus.Instr_i[11:7]};

  cu_alu_decoder u_alu_dec (
    .funct3_i   (f3),
    .funct7_5_i (bus.Instr_i[30]),
    .op5_i      (op[5]),
    .alu_op_o   (alu_dec)
  );

  // Flags_i = {zero, lt, ltu}; funct3 2/3 are not branch encodings.
  always_comb begin
    br_ok = 1'b1;
    taken = 1'b0;
    case (f3)
      3'd0: taken = bus.Flags_i[2];
      3'd1: taken = ~bus.Flags_i[2];
      3'd4: taken = bus.Flags_i[1];
      3'd5: taken = ~bus.Flags_i[1];
      3'd6: taken = bus.Flags_i[0];
      3'd7: taken = ~bus.Flags_i[0];
      default: br_ok = 1'b0;
    endcase
  end

`ifdef MULTICYCLE_CU_TRAP_EN
  logic ill_q, ill_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    berr_d     = berr_q;
    illegal    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_I;
    alu_ctrl   = ALU_ADD;
    result_src = RES_ALU;
`ifdef MULTICYCLE_CU_TRAP_EN
    ill_d      = ill_q;
`endif
    if (rst_i) begin
      // Every strobe stays at its zero default, so an abandoned store never writes.
      state_d = ST_FETCH;
      cnt_d   = '0;
      berr_d  = 1'b0;
`ifdef MULTICYCLE_CU_TRAP_EN
      ill_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (bus.MemReady_i) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (op)
            OP_R, OP_OPIMM:   state_d = ST_EXEC_ALU;
            OP_LOAD, OP_STORE: state_d = ST_MEM_ADR;
            OP_BRANCH:        state_d = ST_BRANCH;
            OP_JAL:           state_d = ST_JAL;
            OP_JALR:          state_d = ST_JALR;
            OP_LUI:           state_d = ST_LUI;
            default:          illegal = 1'b1;
          endcase
        end
        ST_EXEC_ALU: begin
          alu_src  = ~op[5];
          alu_ctrl = alu_dec;
          state_d  = ST_ALU_WB;
        end
        ST_ALU_WB: begin
          reg_write = 1'b1;
          state_d   = ST_FETCH;
        end
        ST_MEM_ADR: begin
          alu_src = 1'b1;
          imm_src = op[5] ? IMM_S : IMM_I;
          state_d = op[5] ? ST_MEM_WR : ST_MEM_RD;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (bus.MemReady_i) state_d = ST_MEM_WB;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          result_src = RES_MEM;
          state_d    = ST_FETCH;
        end
        ST_MEM_WR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (bus.MemReady_i) state_d = ST_FETCH;
        end
        ST_BRANCH: begin
          alu_ctrl = ALU_SUB;
          imm_src  = IMM_B;
          pc_write = br_ok & taken;
          pc_src   = (br_ok & taken) ? PC_OLD_IMM : PC_PLUS4;
          illegal  = ~br_ok;
          state_d  = ST_FETCH;
        end
        ST_JAL: begin
          imm_src    = IMM_J;
          reg_write  = 1'b1;
          result_src = RES_PC4;
          pc_write   = 1'b1;
          pc_src     = PC_OLD_IMM;
          state_d    = ST_FETCH;
        end
        ST_JALR: begin
          alu_src    = 1'b1;
          reg_write  = 1'b1;
          result_src = RES_PC4;
          pc_write   = 1'b1;
          pc_src     = PC_ALU;
          state_d    = ST_FETCH;
        end
        ST_LUI: begin
          imm_src    = IMM_U;
          reg_write  = 1'b1;
          result_src = RES_IMM;
          state_d    = ST_FETCH;
        end
        ST_HALT: ;
        default: state_d = ST_FETCH;
      endcase

      // A ready in the cycle the count would expire still completes normally.
      if (is_wait_state(state_q) && !bus.MemReady_i) begin
        if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_HALT;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef MULTICYCLE_CU_TRAP_EN
      if (illegal) begin
        state_d = ST_HALT;
        ill_d   = 1'b1;
      end
`else
      // Without the trap an illegal instruction retires as a NOP.
      if (illegal) state_d = ST_FETCH;
`endif

      if (state_d != state_q && is_wait_state(state_d)) cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

`ifdef MULTICYCLE_CU_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) ill_q <= 1'b0;
    else       ill_q <= ill_d;
  end
  assign bus.Illegal_o = ill_q & ~rst_i;
`else
  assign bus.Illegal_o = 1'b0;
`endif

  assign bus.MemReq_o    = mem_req;
  assign bus.MemWrite_o  = mem_write;
  assign bus.AdrSrc_o    = adr_src;
  assign bus.IRWrite_o   = ir_write;
  assign bus.PCWrite_o   = pc_write;
  assign bus.PCsrc_o     = pc_src;
  assign bus.RegWrite_o  = reg_write;
  assign bus.ALUsrc_o    = alu_src;
  assign bus.ImmSrc_o    = imm_src;
  assign bus.ALUctrl_o   = ALU_CTRL_W'(alu_ctrl);
  assign bus.ResultSrc_o = result_src;
  assign bus.BusErr_o    = berr_q & ~rst_i;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed test-plan cases then
// randomized instruction streams with random memory wait states.
module tb_multicycle_control_unit;

  localparam int ALU_CTRL_W = 4;
  localparam int TIMEOUT    = 15;
  localparam int CNT_W      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_CTRL_W(ALU_CTRL_W)) bus ();

  multicycle_control_unit #(
    .ALU_CTRL_W (ALU_CTRL_W),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic       req, we, adr, irw, pcw;
    logic [1:0] pcsrc;
    logic       rw, alusrc;
    logic [2:0] imm;
    logic [3:0] alu;
    logic [1:0] res;
    logic       berr, ill;
  } ctl_t;

  int n_assert = 0;
  int n_fail   = 0;
  int fetch_dly = -1;   // -1: random wait states
  int mem_dly   = -1;

  function automatic ctl_t sample();
    ctl_t s;
    s.req = bus.MemReq_o;    s.we = bus.MemWrite_o; s.adr = bus.AdrSrc_o;
    s.irw = bus.IRWrite_o;   s.pcw = bus.PCWrite_o; s.pcsrc = bus.PCsrc_o;
    s.rw = bus.RegWrite_o;   s.alusrc = bus.ALUsrc_o; s.imm = bus.ImmSrc_o;
    s.alu = bus.ALUctrl_o;   s.res = bus.ResultSrc_o;
    s.berr = bus.BusErr_o;   s.ill = bus.Illegal_o;
    return s;
  endfunction

  // One clock: inputs already driven, outputs checked at the falling edge.
  task automatic cyc(input string tag, input ctl_t exp);
    ctl_t obs;
    @(negedge clk);
    obs = sample();
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic plain_step(input string tag, input ctl_t c);
    bus.MemReady_i = 1'($urandom_range(0, 1));
    cyc(tag, c);
  endtask

  task automatic wait_step(input string tag, input int dly, input ctl_t w, input ctl_t d);
    int n;
    n = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
    for (int k = 0; k < n; k++) begin
      bus.MemReady_i = 1'b0;
      cyc({tag, "_wait"}, w);
    end
    bus.MemReady_i = 1'b1;
    cyc(tag, d);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.MemReady_i = 1'b1;
    cyc(tag, '0);
    rst = 1'b0;
  endtask

  // Expected ALU operation from the RV32I mnemonic table.
  function automatic logic [3:0] exp_alu(input logic [31:0] ins);
    logic [3:0] base [8];
    logic [2:0] f3;
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    f3 = ins[14:12];
    if (f3 == 3'd0 && ins[6:0] == 7'd51 && ins[30]) return 4'd1;
    if (f3 == 3'd5 && ins[30]) return 4'd7;
    return base[f3];
  endfunction

  // Walk one instruction through its expected control sequence.
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic [2:0] fl);
    ctl_t w, d, c;
    logic [6:0] op;
    logic [2:0] f3;
    logic tk, bad;
    op  = ins[6:0];
    f3  = ins[14:12];
    bad = 1'b0;
    bus.Instr_i = ins;
    bus.Flags_i = fl;

    w = '0; w.req = 1'b1;
    d = w;  d.irw = 1'b1; d.pcw = 1'b1;
    wait_step({tag, "/fetch"}, fetch_dly, w, d);
    plain_step({tag, "/decode"}, '0);

    c = '0;
    case (op)
      7'd51, 7'd19: begin
        c.alusrc = (op == 7'd19); c.alu = exp_alu(ins);
        plain_step({tag, "/exec"}, c);
        c = '0; c.rw = 1'b1;
        plain_step({tag, "/alu_wb"}, c);
      end
      7'd3: begin
        c.alusrc = 1'b1;
        plain_step({tag, "/mem_adr"}, c);
        w = '0; w.req = 1'b1; w.adr = 1'b1;
        wait_step({tag, "/mem_rd"}, mem_dly, w, w);
        c = '0; c.rw = 1'b1; c.res = 2'd1;
        plain_step({tag, "/mem_wb"}, c);
      end
      7'd35: begin
        c.alusrc = 1'b1; c.imm = 3'd1;
        plain_step({tag, "/mem_adr"}, c);
        w = '0; w.req = 1'b1; w.we = 1'b1; w.adr = 1'b1;
        wait_step({tag, "/mem_wr"}, mem_dly, w, w);
      end
      7'd99: begin
        case (f3)
          3'd0: tk = fl[2];
          3'd1: tk = !fl[2];
          3'd4: tk = fl[1];
          3'd5: tk = !fl[1];
          3'd6: tk = fl[0];
          3'd7: tk = !fl[0];
          default: begin tk = 1'b0; bad = 1'b1; end
        endcase
        c.alu = 4'd1; c.imm = 3'd2; c.pcw = tk; c.pcsrc = tk ? 2'd1 : 2'd0;
        plain_step({tag, "/branch"}, c);
      end
      7'd111: begin
        c.imm = 3'd4; c.rw = 1'b1; c.res = 2'd2; c.pcw = 1'b1; c.pcsrc = 2'd1;
        plain_step({tag, "/jal"}, c);
      end
      7'd103: begin
        c.alusrc = 1'b1; c.rw = 1'b1; c.res = 2'd2; c.pcw = 1'b1; c.pcsrc = 2'd2;
        plain_step({tag, "/jalr"}, c);
      end
      7'd55: begin
        c.imm = 3'd3; c.rw = 1'b1; c.res = 2'd3;
        plain_step({tag, "/lui"}, c);
      end
      default: bad = 1'b1;
    endcase

`ifdef MULTICYCLE_CU_TRAP_EN
    if (bad) begin
      c = '0; c.ill = 1'b1;
      plain_step({tag, "/trap_halt"}, c);
      plain_step({tag, "/trap_halt2"}, c);
      do_reset({tag, "/trap_reset"});
    end
`else
    if (bad) tk = 1'b0;  // illegal retires as NOP; the next fetch step checks the return
`endif
  endtask

  task automatic run_random(input int i);
    logic [31:0] ins, a, b;
    logic [2:0] fl;
    ins = $urandom;
    a   = $urandom;
    case ($urandom_range(0, 2))
      0: b = a;
      1: b = $urandom;
      default: b = a ^ 32'h8000_0000;
    endcase
    fl = {a == b, $signed(a) < $signed(b), a < b};
    case ($urandom_range(0, 8))
      0: begin ins[6:0] = 7'd51; ins[31] = 1'b0; ins[29:25] = 5'd0; end
      1: ins[6:0] = 7'd19;
      2: begin ins[6:0] = 7'd3;  ins[14:12] = 3'd2; end
      3: begin ins[6:0] = 7'd35; ins[14:12] = 3'd2; end
      4: ins[6:0] = 7'd99;
      5: ins[6:0] = 7'd111;
      6: begin ins[6:0] = 7'd103; ins[14:12] = 3'd0; end
      7: ins[6:0] = 7'd55;
      default: begin
        case ($urandom_range(0, 3))
          0: ins[6:0] = 7'h7F;
          1: ins[6:0] = 7'h00;
          2: ins[6:0] = 7'h0F;
          default: ins[6:0] = 7'h17;
        endcase
      end
    endcase
    run_instr($sformatf("rnd%0d", i), ins, fl);
  endtask

  initial begin
    ctl_t w, h;
    bus.Instr_i    = 32'h0;
    bus.Flags_i    = 3'b000;
    bus.MemReady_i = 1'b1;
    @(posedge clk);
    #1;
    do_reset("reset");

    // add x3,x1,x2 with zero wait states
    fetch_dly = 0; mem_dly = 0;
    run_instr("add", 32'h002081B3, 3'b000);
    // lw with three wait cycles in MEM_RD
    mem_dly = 3;
    run_instr("lw_wait3", 32'h0000A103, 3'b000);
    mem_dly = 0;
    run_instr("sw", 32'h0020A023, 3'b000);
    run_instr("beq_taken", 32'h00208063, 3'b100);
    run_instr("beq_not", 32'h00208063, 3'b000);
    run_instr("jalr", 32'h000080E7, 3'b000);
    run_instr("jal", 32'h008000EF, 3'b000);
    run_instr("lui", 32'h123450B7, 3'b000);
    run_instr("sub", 32'h402081B3, 3'b000);
    run_instr("srai", 32'h4030D093, 3'b000);
    run_instr("illegal7f", 32'h0000007F, 3'b000);
    run_instr("blt_f3_2", 32'h0020A063, 3'b010);
    // ready on the last allowed wait cycle completes normally
    fetch_dly = TIMEOUT - 1;
    run_instr("fetch_edge", 32'h002081B3, 3'b000);
    fetch_dly = 0;

    // reset while a store is outstanding: no write strobe that cycle
    bus.Instr_i = 32'h0020A023;
    bus.MemReady_i = 1'b1;
    w = '0; w.req = 1'b1; w.irw = 1'b1; w.pcw = 1'b1;
    cyc("rst_mid/fetch", w);
    cyc("rst_mid/decode", '0);
    w = '0; w.alusrc = 1'b1; w.imm = 3'd1;
    cyc("rst_mid/mem_adr", w);
    do_reset("rst_mid/reset");
    run_instr("after_rst_mid", 32'h002081B3, 3'b000);

    // timeout in FETCH
    bus.MemReady_i = 1'b0;
    w = '0; w.req = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) cyc($sformatf("timeout_wait%0d", k), w);
    h = '0; h.berr = 1'b1;
    cyc("halt_berr", h);
    bus.MemReady_i = 1'b1;
    cyc("halt_stays", h);
    cyc("halt_stays2", h);
    do_reset("halt_reset");
    run_instr("after_halt", 32'h002081B3, 3'b000);

    fetch_dly = -1; mem_dly = -1;
    for (int i = 0; i < 300; i++) run_random(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
